// File: rtl/alu_host_master.sv
// alu_host_master: serializes one ALU command request into the framed UART
// byte stream (opcode, 0x00, LEN lo, LEN hi, operands LSB first), then collects
// the 4-byte little-endian result or reports a timeout.
module alu_host_master #(
    parameter int MAX_OPERANDS   = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CW = $clog2(MAX_OPERANDS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [7:0]                req_opcode_i,
    input  logic [CW-1:0]             req_count_i,
    input  logic [32*MAX_OPERANDS-1:0] req_operands_i,
    output logic [7:0]                tx_tdata_o,
    output logic                      tx_tvalid_o,
    input  logic                      tx_tready_i,
    input  logic [7:0]                rx_tdata_i,
    input  logic                      rx_tvalid_i,
    output logic                      rx_tready_o,
    output logic                      rsp_valid_o,
    output logic [31:0]               rsp_data_o,
    output logic                      rsp_timeout_o,
    output logic                      busy_o
);

    // Byte index into the operand payload; wide enough for 4*MAX_OPERANDS bytes.
    localparam int BW = $clog2(4 * MAX_OPERANDS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_HDR  = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_WAIT_RSP  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Header byte selector: opcode, reserved zero, then 16-bit frame length LSB first.
    function automatic logic [7:0] hdr_byte(input logic [1:0] sel,
                                            input logic [7:0] opcode,
                                            input logic [15:0] len);
        logic [7:0] b;
        case (sel)
            2'd0:    b = opcode;
            2'd1:    b = 8'h00;
            2'd2:    b = len[7:0];
            2'd3:    b = len[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t                    state_r, state_s;
    logic [7:0]                opcode_r, opcode_s;
    logic [CW-1:0]             n_r, n_s;
    logic [32*MAX_OPERANDS-1:0] ops_r, ops_s;
    logic [BW-1:0]             idx_r, idx_s;
    logic [TW-1:0]             tmo_r, tmo_s;
    logic [1:0]                rx_cnt_r, rx_cnt_s;
    logic [31:0]               asm_r, asm_s;
    logic                      tx_tvalid_r, tx_tvalid_s;
    logic [7:0]                tx_tdata_r, tx_tdata_s;
    logic                      req_ready_r, req_ready_s;
    logic                      rsp_valid_r, rsp_valid_s;
    logic [31:0]               rsp_data_r, rsp_data_s;
    logic                      rsp_timeout_r, rsp_timeout_s;
    logic                      busy_r, busy_s;

    logic                      tx_hs_s;
    logic [BW-1:0]             idx_inc_s;
    logic [15:0]               len_s;
    logic [31:0]               asm_new_s;

    assign tx_hs_s   = tx_tvalid_r & tx_tready_i;
    assign idx_inc_s = idx_r + {{(BW-1){1'b0}}, 1'b1};
    assign len_s     = 16'd4 + (16'(n_r) << 2);
    assign asm_new_s = asm_r | ({24'd0, rx_tdata_i} << {rx_cnt_r, 3'b000});

    assign req_ready_o   = req_ready_r;
    assign tx_tdata_o    = tx_tdata_r;
    assign tx_tvalid_o   = tx_tvalid_r;
    assign rx_tready_o   = 1'b1;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_data_o    = rsp_data_r;
    assign rsp_timeout_o = rsp_timeout_r;
    assign busy_o        = busy_r;

    // Next-state and next-register values for the whole engine.
    always_comb begin
        state_s       = state_r;
        opcode_s      = opcode_r;
        n_s           = n_r;
        ops_s         = ops_r;
        idx_s         = idx_r;
        tmo_s         = tmo_r;
        rx_cnt_s      = rx_cnt_r;
        asm_s         = asm_r;
        tx_tvalid_s   = tx_tvalid_r;
        tx_tdata_s    = tx_tdata_r;
        req_ready_s   = req_ready_r;
        rsp_valid_s   = 1'b0;
        rsp_data_s    = rsp_data_r;
        rsp_timeout_s = rsp_timeout_r;

        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid_i && req_ready_r) begin
                    opcode_s    = req_opcode_i;
                    n_s         = (req_count_i > CW'(MAX_OPERANDS)) ? CW'(MAX_OPERANDS) : req_count_i;
                    ops_s       = req_operands_i;
                    idx_s       = '0;
                    tx_tvalid_s = 1'b1;
                    tx_tdata_s  = req_opcode_i;
                    req_ready_s = 1'b0;
                    state_s     = ST_SEND_HDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND_HDR: begin
                if (tx_hs_s) begin
                    if (idx_r[1:0] == 2'd3) begin
                        idx_s = '0;
                        if (n_r != '0) begin
                            tx_tdata_s = ops_r[7:0];
                            state_s    = ST_SEND_DATA;
                        end else begin
                            tx_tvalid_s = 1'b0;
                            tmo_s       = '0;
                            rx_cnt_s    = 2'd0;
                            asm_s       = 32'd0;
                            state_s     = ST_WAIT_RSP;
                        end
                    end else begin
                        idx_s      = idx_inc_s;
                        tx_tdata_s = hdr_byte(idx_inc_s[1:0], opcode_r, len_s);
                    end
                end else begin
                    state_s = ST_SEND_HDR;
                end
            end
            ST_SEND_DATA: begin
                if (tx_hs_s) begin
                    if (16'(idx_r) == (len_s - 16'd5)) begin
                        tx_tvalid_s = 1'b0;
                        tmo_s       = '0;
                        rx_cnt_s    = 2'd0;
                        asm_s       = 32'd0;
                        state_s     = ST_WAIT_RSP;
                    end else begin
                        idx_s      = idx_inc_s;
                        tx_tdata_s = ops_r[{idx_inc_s, 3'b000} +: 8];
                    end
                end else begin
                    state_s = ST_SEND_DATA;
                end
            end
            ST_WAIT_RSP: begin
                // An arriving byte takes priority over an expiring timeout.
                if (rx_tvalid_i) begin
                    tmo_s = '0;
                    asm_s = asm_new_s;
                    if (rx_cnt_r == 2'd3) begin
                        rsp_valid_s   = 1'b1;
                        rsp_data_s    = asm_new_s;
                        rsp_timeout_s = 1'b0;
                        state_s       = ST_DONE;
                    end else begin
                        rx_cnt_s = rx_cnt_r + 2'd1;
                    end
                end else if (tmo_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This increment would reach the limit: report the partial word.
                    rsp_valid_s   = 1'b1;
                    rsp_data_s    = asm_r;
                    rsp_timeout_s = 1'b1;
                    state_s       = ST_DONE;
                end else begin
                    tmo_s = tmo_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                req_ready_s = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                req_ready_s = 1'b0;
                tx_tvalid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_r      <= 8'h00;
            n_r           <= '0;
            ops_r         <= '0;
            idx_r         <= '0;
            tmo_r         <= '0;
            rx_cnt_r      <= 2'd0;
            asm_r         <= 32'd0;
            tx_tvalid_r   <= 1'b0;
            tx_tdata_r    <= 8'h00;
            req_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'd0;
            rsp_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            opcode_r      <= opcode_s;
            n_r           <= n_s;
            ops_r         <= ops_s;
            idx_r         <= idx_s;
            tmo_r         <= tmo_s;
            rx_cnt_r      <= rx_cnt_s;
            asm_r         <= asm_s;
            tx_tvalid_r   <= tx_tvalid_s;
            tx_tdata_r    <= tx_tdata_s;
            req_ready_r   <= req_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_data_r    <= rsp_data_s;
            rsp_timeout_r <= rsp_timeout_s;
            busy_r        <= busy_s;
        end
    end

endmodule

// File: doc/alu_host_master.md
# alu_host_master

Initiator-side engine for the UART ALU byte protocol. It accepts one command as a parallel request (opcode plus up to MAX_OPERANDS 32-bit operands) and serializes it into the framed byte stream that the ALU command FSM consumes. It then collects the 4-byte little-endian result and returns it as one word, or flags a timeout. It sits between a host-side controller (or a loopback test harness) and the 8-bit AXI-stream ports of a uart_tx/uart_rx pair.

## Interface
- MAX_OPERANDS, 4: maximum operands per command (1..255); CW = $clog2(MAX_OPERANDS+1).
- TIMEOUT_CYCLES, 100000: idle clk cycles tolerated between response bytes (≥2).

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  command request valid.
- req_ready_o  out  1  engine idle; request accepted when valid && ready.
- req_opcode_i  in  8  opcode byte.
- req_count_i  in  CW  operand count.
- req_operands_i  in  32*MAX_OPERANDS  operand k at bits [32k+31:32k].
- tx_tdata_o  out  8  byte to uart_tx.
- tx_tvalid_o  out  1  byte valid.
- tx_tready_i  in  1  uart_tx ready.
- rx_tdata_i  in  8  byte from uart_rx.
- rx_tvalid_i  in  1  byte valid.
- rx_tready_o  out  1  always 1 (never backpressures uart_rx).
- rsp_valid_o  out  1  one-cycle pulse; result or timeout.
- rsp_data_o  out  32  result word, held until next pulse.
- rsp_timeout_o  out  1  qualifies rsp_valid_o; 1 = response timed out.
- busy_o  out  1  high in any state except IDLE.

## Operation
- Frame: opcode, 0x00, LEN[7:0], LEN[15:8], then operands 0..N-1, each 4 bytes LSB first. LEN = 4 + 4*N (total frame bytes).
- N = min(req_count_i, MAX_OPERANDS). N = 0 is legal and sends the header only.
- On accept, opcode, N and all operands are captured. Input ports are don't-care afterwards.
- States:
  - IDLE: req_ready_o=1. Accept → SEND_HDR.
  - SEND_HDR: bytes 0..3. After the 4th handshake → SEND_DATA if N>0, else WAIT_RSP.
  - SEND_DATA: byte index 0..4N-1 over the captured operands. After the last handshake → WAIT_RSP.
  - WAIT_RSP: collect 4 rx bytes into rsp_data_o, LSB first. After the 4th byte → DONE.
    - Timeout counter clears on entry and on every rx byte; otherwise increments.
    - Counter reaching TIMEOUT_CYCLES → DONE with timeout.
  - DONE: one cycle. rsp_valid_o=1, then → IDLE.
- Timeout: rsp_timeout_o=1. rsp_data_o holds the partially assembled word, with uncollected bytes 0.
- rx bytes arriving in any state other than WAIT_RSP are consumed and discarded.
- An rx byte arriving in the same cycle the counter hits TIMEOUT_CYCLES wins: the byte is stored and the counter clears.

## Timing
- Reset values: req_ready_o=0 during reset, 1 in the first cycle after release. tx_tvalid_o=0, tx_tdata_o=0x00, rx_tready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0, busy_o=0, state IDLE.
- Accept at edge k → tx_tvalid_o=1 with the opcode in cycle k+1.
- AXI rules: tx_tvalid_o never drops and tx_tdata_o never changes until a handshake. With tready held high, one byte transfers per cycle and the next byte is presented in the following cycle.
- tx_tvalid_o is registered and does not combinationally depend on tx_tready_i.
- Last tx handshake → WAIT_RSP next cycle. 4th rx byte at edge m → rsp_valid_o high in cycle m+1, back in IDLE at m+2.
- req_ready_o deasserts the cycle after accept. No new request is accepted while busy.
- Asynchronous reset mid-frame immediately returns all outputs to reset values. No partial frame is resumed.

## Test plan
- Opcode 0xAD, count 2, operands 3 and 5, tready=1, rx returns 08 00 00 00 → tx bytes AD 00 0C 00 03 00 00 00 05 00 00 00 on 12 consecutive cycles. rsp_valid_o pulses with rsp_data_o=0x00000008 and rsp_timeout_o=0.
- Same request with tready toggling 1-0-0-1 randomly → identical byte sequence. tx_tdata_o stable during every stall.
- Count 0, opcode 0xEC → exactly 4 bytes EC 00 04 00, then WAIT_RSP.
- Count 7 with MAX_OPERANDS=4 → LEN byte 0x14, 20 bytes total.
- TIMEOUT_CYCLES=50, rx returns 2 bytes 34 12, then silence → rsp_valid_o fires 50 cycles after the 2nd byte with rsp_timeout_o=1 and rsp_data_o=0x00001234.
- Reset asserted after byte 5 of a frame → outputs at reset values. A new request after release restarts from the opcode byte. A stray rx byte received in IDLE produces no rsp_valid_o.
